// File: rtl/upsample_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upsampling read path.
package upsample_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_ROW, LOAD, EMIT, DONE} state_t;
    localparam int GUARD_CYC  = 2;
    localparam int UPS_FACTOR = 2;
endpackage

// File: rtl/upsample_line_buf.sv
// One-row line buffer: simple dual-port RAM with a registered read port (latency 1).
module upsample_line_buf #(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/upsample_read_ctrl.sv
// Read sequencer for 2x nearest-neighbour upsampling: loads one input row from the
// FIFO into a line buffer, then streams it twice with every pixel doubled.
module upsample_read_ctrl
    import upsample_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BITS:0]  cfg_col,
    input  logic [ROW_BITS-1:0] cfg_row,
    output logic [ADDR_BITS:0]  fifo_m_count,
    input  logic                fifo_m_ready,
    output logic                fifo_rd_en,
    input  logic [WIDTH-1:0]    fifo_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                out_frame_last,
    output logic                busy,
    output logic                done
);
    localparam int BW = ADDR_BITS + 2;
    localparam logic [BW-1:0] UPS_W = BW'(UPS_FACTOR);

    state_t              state, state_nx;
    logic [ADDR_BITS:0]  col_q, rd_cnt;
    logic [ROW_BITS-1:0] row_q, row_cnt;
    logic [1:0]          guard_cnt;
    logic [BW-1:0]       iss_beat, beats_m1;
    logic                iss_pass, iss_done, iss_last, issue, row_final;
    logic                start_acc, load_fin, pop, acc_end;
    logic [1:0]          occ;

    logic                 vld_p1, last_p1, end_p1, flast_p1;
    logic                 wr_en_p1;
    logic [ADDR_BITS-1:0] wr_addr_p1;
    logic [WIDTH-1:0]     rd_data_p1;

    logic [WIDTH-1:0] sk_data [2];
    logic [1:0]       sk_last, sk_end, sk_flast;
    logic             sk_wp, sk_rp;
    logic [1:0]       sk_cnt;

    assign start_acc = (state == IDLE) && start;
    assign load_fin  = (state == LOAD) && (rd_cnt == col_q);
    assign beats_m1  = BW'(col_q) * UPS_W - BW'(1);
    assign iss_last  = (iss_beat == beats_m1);
    assign row_final = (row_cnt == row_q - ROW_BITS'(1));
    assign pop       = out_valid && out_ready;
    assign acc_end   = pop && sk_end[sk_rp];
    // Reads in flight plus skid entries never exceed the two skid slots.
    assign occ       = sk_cnt + {1'b0, vld_p1};
    assign issue     = (state == EMIT) && !iss_done && ((occ - {1'b0, pop}) < 2'd2);

    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (cfg_col == '0 || cfg_row == '0) ? DONE : WAIT_ROW;
            end
            WAIT_ROW: begin
                busy = 1'b1;
                if (guard_cnt == '0 && fifo_m_ready) state_nx = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                fifo_rd_en = (rd_cnt != col_q);
                if (load_fin) state_nx = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
                if (acc_end) state_nx = sk_flast[sk_rp] ? DONE : WAIT_ROW;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            row_cnt   <= '0;
            rd_cnt    <= '0;
            guard_cnt <= '0;
            iss_beat  <= '0;
            iss_pass  <= 1'b0;
            iss_done  <= 1'b0;
            vld_p1    <= 1'b0;
            wr_en_p1  <= 1'b0;
            sk_wp     <= 1'b0;
            sk_rp     <= 1'b0;
            sk_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                col_q   <= cfg_col;
                row_q   <= cfg_row;
                row_cnt <= '0;
            end else if (acc_end) begin
                row_cnt <= row_cnt + ROW_BITS'(1);
            end
            if (fifo_rd_en)         rd_cnt <= rd_cnt + (ADDR_BITS+1)'(1);
            else if (state != LOAD) rd_cnt <= '0;
            // FIFO ready lags a new threshold or a burst of pops by two cycles.
            if (start_acc || load_fin) guard_cnt <= 2'(GUARD_CYC);
            else if (guard_cnt != '0)  guard_cnt <= guard_cnt - 2'd1;
            if (state != EMIT) begin
                iss_beat <= '0;
                iss_pass <= 1'b0;
                iss_done <= 1'b0;
            end else if (issue) begin
                if (iss_last) begin
                    iss_beat <= '0;
                    iss_pass <= 1'b1;
                    iss_done <= iss_pass;
                end else begin
                    iss_beat <= iss_beat + BW'(1);
                end
            end
            vld_p1   <= issue;
            wr_en_p1 <= fifo_rd_en;
            if (vld_p1) sk_wp <= ~sk_wp;
            if (pop)    sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    // Stage 1: tags travel with the line-buffer read, then land in the skid slots
    always_ff @(posedge clk) begin
        last_p1    <= iss_last;
        end_p1     <= iss_last && iss_pass;
        flast_p1   <= iss_last && iss_pass && row_final;
        wr_addr_p1 <= rd_cnt[ADDR_BITS-1:0];
        if (vld_p1) begin
            sk_data[sk_wp]  <= rd_data_p1;
            sk_last[sk_wp]  <= last_p1;
            sk_end[sk_wp]   <= end_p1;
            sk_flast[sk_wp] <= flast_p1;
        end
    end

    upsample_line_buf #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_line_buf (
        .clk   (clk),
        .we    (wr_en_p1),
        .waddr (wr_addr_p1),
        .wdata (fifo_dout),
        .re    (issue),
        .raddr (iss_beat[ADDR_BITS:1]),
        .rdata (rd_data_p1)
    );

    assign fifo_m_count   = col_q;
    assign out_valid      = (sk_cnt != '0);
    assign out_data       = sk_data[sk_rp];
    assign out_last       = out_valid && sk_last[sk_rp];
    assign out_frame_last = out_valid && sk_flast[sk_rp];
endmodule

// File: tb/tb_upsample_read_ctrl.sv
// Bench for upsample_read_ctrl: FIFO model, random pixels/backpressure, frame-level scoreboard.
module tb_upsample_read_ctrl;
    localparam int W  = 32;
    localparam int AB = 10;
    localparam int RB = 10;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic         f;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AB:0]   cfg_col = '0;
    logic [RB-1:0] cfg_row = '0;
    logic [AB:0]   fifo_m_count;
    logic          fifo_m_ready = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_last, out_frame_last, busy, done;

    always #5 clk = ~clk;

    upsample_read_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .ROW_BITS(RB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_col(cfg_col), .cfg_row(cfg_row),
        .fifo_m_count(fifo_m_count), .fifo_m_ready(fifo_m_ready), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_frame_last(out_frame_last),
        .busy(busy), .done(done)
    );

    logic [W-1:0] fq[$];
    logic [W-1:0] pend_q[$];
    beat_t        exp_q[$];
    beat_t        mon_e;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int underflow = 0, done_cnt = 0, beat_cnt = 0, rd_run = 0;
    int cur_col = 0, feed_per = 0, feed_tick = 0;
    bit rand_ready = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0, prev_flast = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // FIFO with a registered count-vs-threshold flag and one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_m_ready <= 1'b0;
        end else begin
            fifo_m_ready <= (fq.size() >= int'(fifo_m_count));
            if (fifo_rd_en) begin
                if (fq.size() == 0) underflow++;
                else fifo_dout <= fq.pop_front();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && feed_per != 0 && pend_q.size() != 0) begin
            if (feed_tick >= feed_per - 1) begin
                fq.push_back(pend_q.pop_front());
                feed_tick = 0;
            end else begin
                feed_tick++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            rd_run     = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1'b1));
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_flags", 64'({out_last, out_frame_last}), 64'({prev_last, prev_flast}));
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'(1'b1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(mon_e.d));
                    check("beat_last", 64'(out_last), 64'(mon_e.l));
                    check("beat_frame_last", 64'(out_frame_last), 64'(mon_e.f));
                end
                beat_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_flast = out_frame_last;
            if (fifo_rd_en) begin
                if (rd_run == 0) check("rd_en_row_present", 64'(fq.size() >= cur_col), 64'(1'b1));
                rd_run++;
            end else if (rd_run != 0) begin
                check("rd_en_run_len", 64'(rd_run), 64'(cur_col));
                rd_run = 0;
            end
            if (prev_done) check("done_width", 64'(done), 64'(1'b0));
            if (done) done_cnt++;
            prev_done = done;
        end
    end

    // Expected stream: each row twice, each pixel twice per pass
    task automatic load_frame(input int col, input int row, input bit rnd);
        logic [W-1:0] pix[$];
        beat_t e;
        for (int r = 0; r < row; r++) begin
            pix.delete();
            for (int k = 0; k < col; k++) begin
                pix.push_back(rnd ? W'($urandom) : W'(r * col + k));
                pend_q.push_back(pix[k]);
            end
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 2 * col; b++) begin
                    e.d = pix[b / 2];
                    e.l = (b == 2 * col - 1);
                    e.f = e.l && (p == 1) && (r == row - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_frame(input int col, input int row, input bit rnd_pix,
                             input bit rnd_rdy, input int fper, input bit start_at_done);
        int budget;
        bit active;
        active     = (col != 0) && (row != 0);
        cur_col    = col;
        rand_ready = rnd_rdy;
        feed_per   = fper;
        feed_tick  = 0;
        done_cnt   = 0;
        beat_cnt   = 0;
        load_frame(col, row, rnd_pix);
        if (fper == 0) while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
        cfg_col = (AB+1)'(col);
        cfg_row = RB'(row);
        start   = 1'b1;
        step();
        start   = 1'b0;
        cfg_col = (AB+1)'($urandom_range(1, 7));
        cfg_row = RB'($urandom_range(1, 3));
        check("busy_after_start", 64'(busy), 64'(active));
        check("m_count_latched", 64'(fifo_m_count), 64'(col));
        if (active) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        budget = active ? row * col * (10 + fper) + 100 : 0;
        for (int i = 0; i < budget && !done; i++) step();
        check("done_seen", 64'(done), 64'(1'b1));
        if (start_at_done) start = 1'b1;
        step();
        start = 1'b0;
        check("idle_after_done", 64'({busy, done}), 64'(2'b00));
        step();
        check("start_at_done_ignored", 64'(busy), 64'(1'b0));
        check("all_beats_seen", 64'(exp_q.size()), 64'(0));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("fifo_drained", 64'(fq.size()), 64'(0));
        check("no_underflow", 64'(underflow), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check("rst_outputs", 64'({out_valid, fifo_rd_en, busy, done, out_last, out_frame_last}), 64'(6'b0));
        check("rst_m_count", 64'(fifo_m_count), 64'(0));
        rst = 1'b0;
        step();

        run_frame(4, 2, 1'b0, 1'b0, 0, 1'b1);
        run_frame(4, 2, 1'b1, 1'b0, 5, 1'b0);
        run_frame(4, 2, 1'b0, 1'b1, 0, 1'b0);
        run_frame(0, 3, 1'b1, 1'b0, 0, 1'b0);
        run_frame(5, 0, 1'b1, 1'b0, 0, 1'b0);
        run_frame(1024, 3, 1'b1, 1'b0, 0, 1'b0);
        run_frame(3, 2, 1'b1, 1'b1, 3, 1'b1);

        cur_col    = 4;
        rand_ready = 1'b0;
        feed_per   = 0;
        beat_cnt   = 0;
        done_cnt   = 0;
        load_frame(4, 2, 1'b1);
        while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
        cfg_col = 11'd4;
        cfg_row = 10'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 500 && beat_cnt < 20; i++) step();
        check("reached_row1_emit", 64'(beat_cnt >= 20), 64'(1'b1));
        rst = 1'b1;
        exp_q.delete();
        pend_q.delete();
        step();
        check("midrst_outputs", 64'({out_valid, fifo_rd_en, busy, done, out_last, out_frame_last}), 64'(6'b0));
        check("midrst_m_count", 64'(fifo_m_count), 64'(0));
        step();
        rst = 1'b0;
        step();
        run_frame(2, 1, 1'b1, 1'b1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
